// File: rtl/gon_pkg.sv
// Shared definitions for the GON tag scheduler: FSM state encoding, tag widths
// and the packed {col,row} tag pair in GON_FIFO ordering.
package gon_pkg;

    localparam int GON_ROW_TAG_WIDTH = 4;
    localparam int GON_COL_TAG_WIDTH = 4;
    localparam int TAG_PAIR_WIDTH    = GON_ROW_TAG_WIDTH + GON_COL_TAG_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } gon_sched_state_t;

    typedef struct packed {
        logic [GON_COL_TAG_WIDTH-1:0] col;
        logic [GON_ROW_TAG_WIDTH-1:0] row;
    } gon_tag_pair_t;

endpackage

// File: rtl/gon_tag_walker.sv
// 2-D row/column tag counter: walks col_base..col_base+col_count-1 per row,
// counts issued tags and flags the last tag of the rectangle.
module gon_tag_walker #(
    parameter int ROW_TAG_WIDTH = 4,
    parameter int COL_TAG_WIDTH = 4,
    parameter int CNT_WIDTH     = ROW_TAG_WIDTH + COL_TAG_WIDTH
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_load,
    input  logic                     i_step,
    input  logic [ROW_TAG_WIDTH-1:0] i_row_base,
    input  logic [COL_TAG_WIDTH-1:0] i_col_base,
    input  logic [COL_TAG_WIDTH-1:0] i_col_count,
    input  logic [CNT_WIDTH-1:0]     i_total,
    output logic [ROW_TAG_WIDTH-1:0] o_row_tag,
    output logic [COL_TAG_WIDTH-1:0] o_col_tag,
    output logic                     o_last
);

    localparam logic [CNT_WIDTH-1:0]     CNT_ONE = 1;
    localparam logic [COL_TAG_WIDTH-1:0] COL_ONE = 1;
    localparam logic [ROW_TAG_WIDTH-1:0] ROW_ONE = 1;

    logic [ROW_TAG_WIDTH-1:0] r_row;
    logic [COL_TAG_WIDTH-1:0] r_col;
    logic [COL_TAG_WIDTH-1:0] r_col_base;
    logic [COL_TAG_WIDTH-1:0] r_col_last;
    logic [CNT_WIDTH-1:0]     r_issued;

    // Last column is precomputed at load; arithmetic wraps modulo 2^width.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_row      <= '0;
            r_col      <= '0;
            r_col_base <= '0;
            r_col_last <= '0;
            r_issued   <= '0;
        end else if (i_load) begin
            r_row      <= i_row_base;
            r_col      <= i_col_base;
            r_col_base <= i_col_base;
            r_col_last <= i_col_base + i_col_count - COL_ONE;
            r_issued   <= '0;
        end else if (i_step) begin
            r_issued <= r_issued + CNT_ONE;
            if (r_col == r_col_last) begin
                r_col <= r_col_base;
                r_row <= r_row + ROW_ONE;
            end else begin
                r_col <= r_col + COL_ONE;
            end
        end
    end

    assign o_row_tag = r_row;
    assign o_col_tag = r_col;
    assign o_last    = (r_issued == i_total - CNT_ONE);

endmodule

// File: rtl/gon_tag_scheduler.sv
// Sequences one GON_FIFO transaction: pushes a rectangle of {col,row} tags and
// drains the same number of data words. Range check enabled by GON_SCHED_CFG_CHECK_EN.
module gon_tag_scheduler
    import gon_pkg::*;
#(
    parameter int ROW_TAG_WIDTH = GON_ROW_TAG_WIDTH,
    parameter int COL_TAG_WIDTH = GON_COL_TAG_WIDTH,
    parameter int NUM_OF_ROWS   = 12,
    parameter int NUM_OF_COLS   = 14
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [ROW_TAG_WIDTH-1:0] i_row_base,
    input  logic [ROW_TAG_WIDTH-1:0] i_row_count,
    input  logic [COL_TAG_WIDTH-1:0] i_col_base,
    input  logic [COL_TAG_WIDTH-1:0] i_col_count,
    output logic [ROW_TAG_WIDTH-1:0] o_row_tag,
    output logic [COL_TAG_WIDTH-1:0] o_col_tag,
    output logic                     o_tags_wr_en,
    input  logic                     i_tags_full,
    output logic                     o_data_rd_en,
    input  logic                     i_data_empty,
    input  logic                     i_sink_ready,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_cfg_err,
    output logic [1:0]               o_state
);

    localparam int                   CNT_WIDTH = ROW_TAG_WIDTH + COL_TAG_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = 1;

    gon_sched_state_t r_state, w_next_state;
    logic [CNT_WIDTH-1:0] r_total;
    logic [CNT_WIDTH-1:0] r_read;
    logic [CNT_WIDTH-1:0] w_total;
    logic                 w_load;
    logic                 w_step;
    logic                 w_last;
    logic                 w_cfg_bad;
    logic                 w_rd_en;

    assign w_total = {{COL_TAG_WIDTH{1'b0}}, i_row_count} * {{ROW_TAG_WIDTH{1'b0}}, i_col_count};

`ifdef GON_SCHED_CFG_CHECK_EN
    logic r_cfg_err;

    assign w_cfg_bad = ((int'(i_row_base) + int'(i_row_count)) > NUM_OF_ROWS) ||
                       ((int'(i_col_base) + int'(i_col_count)) > NUM_OF_COLS);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cfg_err <= 1'b0;
        end else if (w_load && w_cfg_bad) begin
            r_cfg_err <= 1'b1;
        end
    end

    assign o_cfg_err = r_cfg_err;
`else
    assign w_cfg_bad = 1'b0;
    assign o_cfg_err = 1'b0;
`endif

    // Read side runs alongside issue so data can drain at full rate.
    assign w_rd_en = ((r_state == S_ISSUE) || (r_state == S_DRAIN)) &&
                     !i_data_empty && i_sink_ready && (r_read < r_total);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_total <= '0;
            r_read  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_total <= w_cfg_bad ? '0 : w_total;
                r_read  <= '0;
            end else if (w_rd_en) begin
                r_read <= r_read + CNT_ONE;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_tags_wr_en = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_load = 1'b1;
                    if (w_cfg_bad || (w_total == '0)) w_next_state = S_DONE;
                    else                              w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_tags_wr_en = !i_tags_full;
                w_step       = !i_tags_full;
                if (!i_tags_full && w_last) w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if ((r_read == r_total) || (w_rd_en && (r_read + CNT_ONE == r_total)))
                    w_next_state = S_DONE;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    gon_tag_walker #(
        .ROW_TAG_WIDTH (ROW_TAG_WIDTH),
        .COL_TAG_WIDTH (COL_TAG_WIDTH),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_walker (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_row_base  (i_row_base),
        .i_col_base  (i_col_base),
        .i_col_count (i_col_count),
        .i_total     (r_total),
        .o_row_tag   (o_row_tag),
        .o_col_tag   (o_col_tag),
        .o_last      (w_last)
    );

    assign o_data_rd_en = w_rd_en;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);
    assign o_state      = r_state;

endmodule

// File: tb/tb_gon_tag_scheduler.sv
// Bench for gon_tag_scheduler: table of transactions plus hand-written
// restart, mid-transaction reset and configuration-error sequences.
module tb_gon_tag_scheduler;
    import gon_pkg::*;

    localparam int RW = GON_ROW_TAG_WIDTH;
    localparam int CW = GON_COL_TAG_WIDTH;
    localparam int TW = TAG_PAIR_WIDTH;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_start = 1'b0;
    logic [RW-1:0] i_row_base = '0;
    logic [RW-1:0] i_row_count = '0;
    logic [CW-1:0] i_col_base = '0;
    logic [CW-1:0] i_col_count = '0;
    logic          i_tags_full = 1'b0;
    logic          i_data_empty = 1'b1;
    logic          i_sink_ready = 1'b1;
    logic [RW-1:0] o_row_tag;
    logic [CW-1:0] o_col_tag;
    logic          o_tags_wr_en;
    logic          o_data_rd_en;
    logic          o_busy;
    logic          o_done;
    logic          o_cfg_err;
    logic [1:0]    o_state;

    int n_checks = 0;
    int n_fail   = 0;
    int fifo_cnt = 0;
    logic [TW-1:0] exp_q[$];

    typedef struct {
        int rb;
        int rc;
        int cb;
        int cc;
        bit bp;
        int exp_done_c;
    } txn_vec_t;

    always #5 clk = ~clk;

    gon_tag_scheduler dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_row_base   (i_row_base),
        .i_row_count  (i_row_count),
        .i_col_base   (i_col_base),
        .i_col_count  (i_col_count),
        .o_row_tag    (o_row_tag),
        .o_col_tag    (o_col_tag),
        .o_tags_wr_en (o_tags_wr_en),
        .i_tags_full  (i_tags_full),
        .o_data_rd_en (o_data_rd_en),
        .i_data_empty (i_data_empty),
        .i_sink_ready (i_sink_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_cfg_err    (o_cfg_err),
        .o_state      (o_state)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row_tag"}, int'(o_row_tag), 0);
        check({tag, "_col_tag"}, int'(o_col_tag), 0);
        check({tag, "_wr_en"},   int'(o_tags_wr_en), 0);
        check({tag, "_rd_en"},   int'(o_data_rd_en), 0);
        check({tag, "_busy"},    int'(o_busy), 0);
        check({tag, "_done"},    int'(o_done), 0);
        check({tag, "_cfg_err"}, int'(o_cfg_err), 0);
        check({tag, "_state"},   int'(o_state), 0);
    endtask

    // Cycle 0 carries start; the data FIFO model exposes each pushed word one cycle later.
    task automatic run_txn(input int rb, input int rc, input int cb, input int cc,
                           input bit bp, input int exp_done_c, input int start2_c,
                           input int rst_after, input bit exp_err, input bit exp_cfg);
        int pushes = 0;
        int pops = 0;
        int done_c = -1;
        int exp_n;
        bit finished = 1'b0;
        gon_tag_pair_t tp;
        exp_q.delete();
        fifo_cnt = 0;
        if (!exp_err) begin
            for (int r = 0; r < rc; r++) begin
                for (int c = 0; c < cc; c++) begin
                    tp.row = RW'(rb + r);
                    tp.col = CW'(cb + c);
                    exp_q.push_back(tp);
                end
            end
        end
        exp_n = exp_q.size();
        i_row_base  = RW'(rb);
        i_row_count = RW'(rc);
        i_col_base  = CW'(cb);
        i_col_count = CW'(cc);
        for (int c = 0; c < 400 && !finished; c++) begin
            @(negedge clk);
            i_start      = (c == 0) || (c == start2_c);
            i_tags_full  = bp && (c >= 3) && (c <= 6);
            i_sink_ready = bp ? (c % 2 == 1) : 1'b1;
            i_data_empty = (fifo_cnt == 0);
            #1;
            if (o_tags_wr_en) begin
                pushes++;
                check("push_while_full", int'(i_tags_full), 0);
                if (exp_q.size() == 0) begin
                    check("push_count_exceeded", pushes, exp_n);
                end else begin
                    tp = exp_q.pop_front();
                    check("push_tag", int'({o_col_tag, o_row_tag}), int'(tp));
                end
            end
            if (o_data_rd_en) begin
                pops++;
                check("pop_allowed", int'(i_sink_ready && !i_data_empty), 1);
                fifo_cnt--;
            end
            if (o_tags_wr_en) fifo_cnt++;
            if (done_c >= 0) begin
                check("busy_after_done", int'(o_busy), 0);
                check("done_one_cycle", int'(o_done), 0);
                finished = 1'b1;
            end else if (o_done) begin
                done_c = c;
            end
            if (rst_after > 0 && pushes == rst_after) finished = 1'b1;
        end
        i_start = 1'b0;
        if (rst_after > 0) begin
            check("pushes_before_reset", pushes, rst_after);
        end else begin
            check("done_seen", int'(done_c >= 0), 1);
            if (exp_done_c >= 0) check("done_cycle", done_c, exp_done_c);
            check("push_total", pushes, exp_n);
            check("pop_total", pops, exp_n);
            check("cfg_err", int'(o_cfg_err), int'(exp_cfg));
        end
    endtask

    initial begin
        txn_vec_t vecs[6];
        vecs[0] = '{rb: 2, rc: 3, cb: 3, cc: 4, bp: 1'b0, exp_done_c: 14};
        vecs[1] = '{rb: 2, rc: 3, cb: 3, cc: 4, bp: 1'b1, exp_done_c: -1};
        vecs[2] = '{rb: 2, rc: 0, cb: 3, cc: 4, bp: 1'b0, exp_done_c: 1};
        vecs[3] = '{rb: 0, rc: 1, cb: 0, cc: 1, bp: 1'b0, exp_done_c: 3};
        vecs[4] = '{rb: 0, rc: 2, cb: 8, cc: 5, bp: 1'b0, exp_done_c: 12};
        vecs[5] = '{rb: 1, rc: 4, cb: 9, cc: 5, bp: 1'b1, exp_done_c: -1};

        i_reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        i_reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].rb, vecs[i].rc, vecs[i].cb, vecs[i].cc, vecs[i].bp,
                    vecs[i].exp_done_c, -1, 0, 1'b0, 1'b0);
        end

        // Second start during ISSUE must not disturb the walk.
        run_txn(2, 3, 3, 4, 1'b0, 14, 4, 0, 1'b0, 1'b0);

        // Reset after five pushes, then a clean restart.
        run_txn(2, 3, 3, 4, 1'b0, -1, -1, 5, 1'b0, 1'b0);
        @(negedge clk);
        i_reset      = 1'b1;
        i_tags_full  = 1'b1;
        i_data_empty = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        i_tags_full = 1'b0;
        run_txn(2, 3, 3, 4, 1'b0, 14, -1, 0, 1'b0, 1'b0);

`ifdef GON_SCHED_CFG_CHECK_EN
        run_txn(10, 4, 0, 1, 1'b0, 1, -1, 0, 1'b1, 1'b1);
        run_txn(2, 3, 3, 4, 1'b0, 14, -1, 0, 1'b0, 1'b1);
`else
        // Tag wrap modulo 16 on both row and column.
        run_txn(14, 3, 13, 4, 1'b0, 14, -1, 0, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gon_tag_scheduler.md
# gon_tag_scheduler

Sequences one GON_FIFO transaction: walks a configured rectangle of PE row/column tags, pushes one {col,row} tag per cycle into the GON tags FIFO under `tags_full` back-pressure, and drains exactly the matching number of words from the GON data FIFO under `data_empty` / sink back-pressure. Sits between the top-level layer controller and GON_FIFO, and owns the `row_tag`, `col_tag`, `tags_wr_en` and `data_rd_en` pins of that block.

## Interface
- `ROW_TAG_WIDTH`, 4, row tag / row count width
- `COL_TAG_WIDTH`, 4, column tag / column count width
- `NUM_OF_ROWS`, 12, PE array rows (range check)
- `NUM_OF_COLS`, 14, PE array columns (range check)
- `clk` in 1, single clock
- `reset` in 1, synchronous, active-high
- `start` in 1, launch transaction; honoured only in IDLE
- `row_base` in ROW_TAG_WIDTH, first row tag
- `row_count` in ROW_TAG_WIDTH, rows to walk
- `col_base` in COL_TAG_WIDTH, first column tag
- `col_count` in COL_TAG_WIDTH, columns per row
- `row_tag` out ROW_TAG_WIDTH, tag to GON_FIFO
- `col_tag` out COL_TAG_WIDTH, tag to GON_FIFO
- `tags_wr_en` out 1, tag push strobe
- `tags_full` in 1, tags FIFO full
- `data_rd_en` out 1, data pop strobe
- `data_empty` in 1, data FIFO empty
- `sink_ready` in 1, downstream accepts a word this cycle
- `busy` out 1, transaction in progress
- `done` out 1, one-cycle completion pulse
- `cfg_err` out 1, sticky config error (macro only)

## Operation
- FSM: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on `start`, latch bases and counts, load `row_tag=row_base`, `col_tag=col_base`, clear counters, set `total = row_count*col_count` (ROW_TAG_WIDTH+COL_TAG_WIDTH bits, unsigned, no overflow possible). Go to ISSUE, or DONE if `total==0`.
- ISSUE: `tags_wr_en = !tags_full`. On each push, column increments. When column reaches `col_base+col_count-1`, column reloads `col_base` and row increments. After the push of the last tag (`issued==total-1`), go to DRAIN.
- Tag arithmetic wraps modulo 2^width. No range check without the macro.
- Read side is active in ISSUE and DRAIN: `data_rd_en = !data_empty && sink_ready && (read < total)`. Each strobe increments `read`.
- DRAIN: when `read==total`, including the strobe cycle itself, go to DONE.
- DONE: `done=1` for one cycle, then IDLE.
- `busy=1` in ISSUE, DRAIN and DONE.
- `start` outside IDLE is ignored. No queuing.
- Never pushes more than `total` tags and never pops more than `total` words.
- `reset` mid-transaction: return to IDLE next edge and drop all counters. FIFO contents are not flushed by this block; GON_FIFO shares `reset`.

## Timing
- Reset values: `row_tag=0`, `col_tag=0`, `tags_wr_en=0`, `data_rd_en=0`, `busy=0`, `done=0`, `cfg_err=0`.
- `start` sampled at edge N. The first `tags_wr_en` can assert in cycle N+1.
- `tags_wr_en` and `data_rd_en` are combinational from state/counters and the FIFO flags. Tags are registered.
- Peak rate: one tag and one data word per cycle, concurrently.
- Minimum transaction of k tags with no back-pressure and one-cycle GON turnaround: `done` at N+k+2 at earliest.
- `total==0`: `done` asserts in cycle N+1 with no strobes.

## Configuration
- `GON_SCHED_CFG_CHECK_EN` defined: at `start`, flag an error if `row_base+row_count > NUM_OF_ROWS` or `col_base+col_count > NUM_OF_COLS` (widened compare). On error, set `cfg_err` (sticky until `reset`), issue no strobes, and go straight to DONE.
- Not defined: no check. `cfg_err` is tied to 0 and tags wrap as above.

## Structure
- Shared package `gon_pkg` holds:
  - FSM state enum `gon_sched_state_t`
  - `TAG_PAIR_WIDTH = ROW_TAG_WIDTH+COL_TAG_WIDTH`
  - packed tag struct `{col,row}`, matching the GON_FIFO tag ordering
- One natural sub-module: `gon_tag_walker`, the 2-D row/column counter with last-tag detect. FSM and read counter stay in the top.

## Test plan
- Base (2,3), count 3×4, no back-pressure:
  - 12 pushes, in order (r2,c3..c6), (r3,c3..c6), (r4,c3..c6).
  - 12 pops, then `done` once.
  - `busy` falls the cycle after `done`.
- Same transaction with `tags_full` high for cycles 3–6 and `sink_ready` toggling every cycle:
  - no push while full, no pop while `sink_ready=0`.
  - Totals are still exactly 12 pushes / 12 pops.
- `row_count=0`: `done` in cycle N+1, zero strobes. With the macro, `cfg_err` stays 0.
- Second `start` pulse during ISSUE: ignored, with no counter or tag disturbance.
- `reset` asserted after 5 pushes: all outputs at reset values next cycle, FSM in IDLE, and a new `start` begins cleanly.
- Macro on, base row 10, count 4 (exceeds 12): `cfg_err=1`, no strobes, `done` pulse. `cfg_err` holds through the next valid transaction.
